// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single wide data-memory port.
// Supports locked multi-beat ownership with a forced break, and tags reads so data returns to the issuer.
module mem_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 256,
  parameter int BE_W     = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              rden0,
  input  logic              rden1,
  input  logic              wren0,
  input  logic              wren1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [BE_W-1:0]   be0,
  input  logic [BE_W-1:0]   be1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              lock_err,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteena,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state;
  logic              last_served;
  logic [CNT_W-1:0]  lock_cnt;
  logic [RD_LAT-1:0] rd_valid;
  logic [RD_LAT-1:0] rd_port;

  logic beat0, beat1;
  logic owner_is1, cur_req, cur_lock, oth_req;

  assign gnt0 = (state == OWN0);
  assign gnt1 = (state == OWN1);

  assign beat0 = gnt0 & req0 & (rden0 | wren0);
  assign beat1 = gnt1 & req1 & (rden1 | wren1);

  // The owner's view of the request lines lets both OWN states share one transition rule.
  assign owner_is1 = (state == OWN1);
  assign cur_req   = owner_is1 ? req1  : req0;
  assign cur_lock  = owner_is1 ? lock1 : lock0;
  assign oth_req   = owner_is1 ? req0  : req1;

  always_comb begin
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    mem_address = '0;
    mem_byteena = '0;
    mem_data    = '0;
    if (beat0) begin
      mem_wren    = wren0;
      mem_rden    = rden0 & ~wren0;
      mem_address = addr0;
      mem_byteena = be0;
      mem_data    = wdata0;
    end else if (beat1) begin
      mem_wren    = wren1;
      mem_rden    = rden1 & ~wren1;
      mem_address = addr1;
      mem_byteena = be1;
      mem_data    = wdata1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
      lock_cnt    <= '0;
      lock_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          lock_cnt <= '0;
          if (req0 && req1) state <= last_served ? OWN0 : OWN1;
          else if (req0)    state <= OWN0;
          else if (req1)    state <= OWN1;
        end
        OWN0, OWN1: begin
          if (!cur_req) begin
            state       <= oth_req ? (owner_is1 ? OWN0 : OWN1) : IDLE;
            last_served <= owner_is1;
            lock_cnt    <= '0;
          end else if (cur_lock && oth_req) begin
            // A lock that starves the other port for MAX_LOCK cycles is broken and flagged.
            if (lock_cnt == CNT_W'(MAX_LOCK - 1)) begin
              state       <= owner_is1 ? OWN0 : OWN1;
              last_served <= owner_is1;
              lock_err    <= 1'b1;
              lock_cnt    <= '0;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end else if (!cur_lock && oth_req) begin
            state       <= owner_is1 ? OWN0 : OWN1;
            last_served <= owner_is1;
            lock_cnt    <= '0;
          end else begin
            lock_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read tags travel alongside the IP latency so data lands on the issuing port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= '0;
      rd_port  <= '0;
    end else begin
      rd_valid[0] <= mem_rden;
      rd_port[0]  <= gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_valid[i] <= rd_valid[i-1];
        rd_port[i]  <= rd_port[i-1];
      end
    end
  end

  assign rvalid0 = rd_valid[RD_LAT-1] & ~rd_port[RD_LAT-1];
  assign rvalid1 = rd_valid[RD_LAT-1] &  rd_port[RD_LAT-1];
  assign rdata   = rd_valid[RD_LAT-1] ? mem_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, hand-written lock/reset sequences and random traffic,
// all checked against a transaction-level model of arbitration and read return.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 256;
  localparam int BE_W     = 32;
  localparam int RD_LAT   = 2;
  localparam int MAX_LOCK = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
  logic rden0 = 0, rden1 = 0, wren0 = 0, wren1 = 0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [BE_W-1:0]   be0 = '0, be1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, lock_err, mem_rden, mem_wren;
  logic [DATA_W-1:0] rdata, mem_data, mem_q;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteena;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .rden0(rden0), .rden1(rden1), .wren0(wren0), .wren1(wren1),
    .addr0(addr0), .addr1(addr1), .be0(be0), .be1(be1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .lock_err(lock_err),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_address(mem_address),
    .mem_byteena(mem_byteena), .mem_data(mem_data), .mem_q(mem_q)
  );

  // Behavioural memory IP: byte-enabled writes, reads returned RD_LAT cycles later, junk otherwise.
  logic [DATA_W-1:0] ip_mem [16];
  logic [DATA_W-1:0] q_pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_wren)
      for (int b = 0; b < BE_W; b++)
        if (mem_byteena[b]) ip_mem[mem_address[3:0]][b*8 +: 8] <= mem_data[b*8 +: 8];
    q_pipe[0] <= mem_rden ? ip_mem[mem_address[3:0]] : {8{32'hDEADBEEF}};
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q = q_pipe[RD_LAT-1];

  typedef struct {
    bit rst;
    bit req0, req1, lock0, lock1, rden0, rden1, wren0, wren1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [BE_W-1:0]   be0, be1;
    logic [DATA_W-1:0] wdata0, wdata1;
  } vec_t;

  typedef struct {
    vec_t v;
    bit g0, g1, rden, wren;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    bit rv0, rv1;
  } row_t;

  typedef struct {
    int due;
    bit port;
    logic [DATA_W-1:0] data;
  } rd_t;

  int tests = 0;
  int failed = 0;

  // Reference model state: owner -1 means nobody holds the memory.
  int  m_owner = -1;
  int  m_last = 1;
  int  m_cnt = 0;
  bit  m_err = 0;
  int  m_cyc = 0;
  rd_t pend[$];

  logic s_gnt0, s_gnt1, s_rv0, s_rv1, s_rden, s_wren, s_lock_err;
  logic [ADDR_W-1:0] s_addr;
  logic [BE_W-1:0]   s_be;

  function automatic vec_t mk(bit r0, bit r1, bit l0, bit rd0, bit rd1, bit wr0, int a0, int a1);
    vec_t v;
    v.rst = 1; v.req0 = r0; v.req1 = r1; v.lock0 = l0; v.lock1 = 0;
    v.rden0 = rd0; v.rden1 = rd1; v.wren0 = wr0; v.wren1 = 0;
    v.addr0 = ADDR_W'(a0); v.addr1 = ADDR_W'(a1);
    v.be0 = '1; v.be1 = '1;
    v.wdata0 = {8{32'hA000_0000 | 32'(a0)}};
    v.wdata1 = {8{32'hB000_0000 | 32'(a1)}};
    return v;
  endfunction

  function automatic row_t rw(vec_t v, bit g0, bit g1, bit rd, bit wr, int a, logic [BE_W-1:0] be,
                              bit rv0, bit rv1);
    row_t r;
    r.v = v; r.g0 = g0; r.g1 = g1; r.rden = rd; r.wren = wr;
    r.addr = ADDR_W'(a); r.be = be; r.rv0 = rv0; r.rv1 = rv1;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, m_cyc, act, exp);
    end
  endtask

  // Drives one cycle, checks every output against the model, then advances the model across the edge.
  task automatic apply_stimulus(input vec_t v);
    bit rq[2], lk[2], rd[2], wr[2];
    bit beat, e_rden, e_wren, e_rv0, e_rv1;
    logic [ADDR_W-1:0] e_addr;
    logic [BE_W-1:0]   e_be;
    logic [DATA_W-1:0] e_data, e_rdata;
    int k, o;
    rst = v.rst; req0 = v.req0; req1 = v.req1; lock0 = v.lock0; lock1 = v.lock1;
    rden0 = v.rden0; rden1 = v.rden1; wren0 = v.wren0; wren1 = v.wren1;
    addr0 = v.addr0; addr1 = v.addr1; be0 = v.be0; be1 = v.be1;
    wdata0 = v.wdata0; wdata1 = v.wdata1;
    if (!v.rst) begin
      m_owner = -1; m_last = 1; m_cnt = 0; m_err = 0; pend.delete();
    end
    #1;
    rq = '{v.req0, v.req1}; lk = '{v.lock0, v.lock1};
    rd = '{v.rden0, v.rden1}; wr = '{v.wren0, v.wren1};
    beat = (m_owner >= 0) && rq[m_owner] && (rd[m_owner] || wr[m_owner]);
    e_wren = beat && wr[m_owner];
    e_rden = beat && rd[m_owner] && !wr[m_owner];
    e_addr = '0; e_be = '0; e_data = '0;
    if (beat) begin
      e_addr = (m_owner == 1) ? v.addr1 : v.addr0;
      e_be   = (m_owner == 1) ? v.be1 : v.be0;
      e_data = (m_owner == 1) ? v.wdata1 : v.wdata0;
    end
    e_rv0 = 0; e_rv1 = 0; e_rdata = '0;
    if (pend.size() > 0 && pend[0].due == m_cyc) begin
      if (pend[0].port) e_rv1 = 1; else e_rv0 = 1;
      e_rdata = pend[0].data;
      void'(pend.pop_front());
    end
    s_gnt0 = gnt0; s_gnt1 = gnt1; s_rv0 = rvalid0; s_rv1 = rvalid1;
    s_rden = mem_rden; s_wren = mem_wren; s_addr = mem_address; s_be = mem_byteena;
    s_lock_err = lock_err;
    check_output("gnt0", gnt0, m_owner == 0);
    check_output("gnt1", gnt1, m_owner == 1);
    check_output("mem_rden", mem_rden, e_rden);
    check_output("mem_wren", mem_wren, e_wren);
    check_output("mem_address", mem_address, e_addr);
    check_output("mem_byteena", mem_byteena, e_be);
    check_output("mem_data", mem_data, e_data);
    check_output("rvalid0", rvalid0, e_rv0);
    check_output("rvalid1", rvalid1, e_rv1);
    check_output("rdata", rdata, e_rdata);
    check_output("lock_err", lock_err, m_err);
    if (e_rden) pend.push_back(rd_t'{m_cyc + RD_LAT, m_owner == 1, ip_mem[e_addr[3:0]]});
    if (v.rst) begin
      if (m_owner < 0) begin
        if (rq[0] && rq[1]) m_owner = (m_last == 1) ? 0 : 1;
        else if (rq[0])     m_owner = 0;
        else if (rq[1])     m_owner = 1;
        m_cnt = 0;
      end else begin
        k = m_owner; o = 1 - k;
        if (!rq[k]) begin
          m_owner = rq[o] ? o : -1; m_last = k; m_cnt = 0;
        end else if (lk[k] && rq[o]) begin
          m_cnt++;
          if (m_cnt >= MAX_LOCK) begin
            m_owner = o; m_last = k; m_err = 1; m_cnt = 0;
          end
        end else if (rq[o]) begin
          m_owner = o; m_last = k; m_cnt = 0;
        end else begin
          m_cnt = 0;
        end
      end
    end
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  row_t tbl[18];
  vec_t t, z, zr;
  int n;
  bit l0r, l1r;

  initial begin
    z = mk(0, 0, 0, 0, 0, 0, 0, 0);
    zr = z; zr.rst = 0;

    t = mk(1, 0, 0, 0, 0, 1, 1, 0); t.be0 = 32'h0003_0000; t.wdata0 = 256'h5678 << 128;
    tbl[0]  = rw(t, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = rw(t, 1, 0, 0, 1, 1, 32'h0003_0000, 0, 0);
    tbl[2]  = rw(z, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = rw(z, 0, 0, 0, 0, 0, 0, 0, 0);
    t = mk(1, 1, 0, 1, 1, 0, 2, 3);
    tbl[4]  = rw(t, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = rw(t, 0, 1, 1, 0, 3, '1, 0, 0);
    tbl[6]  = rw(t, 1, 0, 1, 0, 2, '1, 0, 0);
    tbl[7]  = rw(t, 0, 1, 1, 0, 3, '1, 0, 1);
    tbl[8]  = rw(t, 1, 0, 1, 0, 2, '1, 1, 0);
    tbl[9]  = rw(z, 0, 1, 0, 0, 0, 0, 0, 1);
    tbl[10] = rw(z, 0, 0, 0, 0, 0, 0, 1, 0);
    t = mk(1, 1, 1, 0, 1, 1, 0, 5); t.be0 = 32'h0000_FFFF;
    tbl[11] = rw(t, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = rw(t, 1, 0, 0, 1, 0, 32'h0000_FFFF, 0, 0);
    t = mk(1, 1, 0, 0, 1, 1, 1, 5); t.be0 = 32'hFFFF_0000;
    tbl[13] = rw(t, 1, 0, 0, 1, 1, 32'hFFFF_0000, 0, 0);
    tbl[14] = rw(mk(0, 1, 0, 0, 1, 0, 0, 5), 0, 1, 1, 0, 5, '1, 0, 0);
    tbl[15] = rw(z, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[16] = rw(z, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[17] = rw(z, 0, 0, 0, 0, 0, 0, 0, 0);

    apply_stimulus(zr);
    apply_stimulus(zr);

    $display("[TB] directed table");
    for (int i = 0; i < 18; i++) begin
      apply_stimulus(tbl[i].v);
      check_output($sformatf("tbl%0d_gnt0", i), s_gnt0, tbl[i].g0);
      check_output($sformatf("tbl%0d_gnt1", i), s_gnt1, tbl[i].g1);
      check_output($sformatf("tbl%0d_rden", i), s_rden, tbl[i].rden);
      check_output($sformatf("tbl%0d_wren", i), s_wren, tbl[i].wren);
      check_output($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
      check_output($sformatf("tbl%0d_be", i), s_be, tbl[i].be);
      check_output($sformatf("tbl%0d_rv0", i), s_rv0, tbl[i].rv0);
      check_output($sformatf("tbl%0d_rv1", i), s_rv1, tbl[i].rv1);
    end

    $display("[TB] forced lock break");
    apply_stimulus(mk(1, 0, 1, 0, 0, 0, 0, 0));
    n = 0;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(mk(1, 1, 1, 0, 0, 0, 0, 0));
      if (s_gnt1) break;
      if (s_gnt0) n++;
    end
    check_output("lock_hold_cycles", n, MAX_LOCK);
    check_output("lock_break_gnt1", s_gnt1, 1);
    check_output("lock_break_err", s_lock_err, 1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(z);
      check_output("lock_err_sticky", s_lock_err, 1);
    end

    $display("[TB] reset during read");
    t = mk(1, 0, 0, 1, 0, 0, 16, 0);
    apply_stimulus(t);
    apply_stimulus(t);
    check_output("rst_read_beat", s_rden, 1);
    apply_stimulus(zr);
    check_output("rst_lock_err_clear", s_lock_err, 0);
    apply_stimulus(zr);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(z);
      check_output("rst_no_rvalid0", s_rv0, 0);
    end
    t = mk(1, 1, 0, 0, 0, 0, 0, 0);
    apply_stimulus(t);
    apply_stimulus(t);
    check_output("rst_first_tie_port0", s_gnt0, 1);

    $display("[TB] random traffic");
    l0r = 0; l1r = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) l0r = ~l0r;
      if ($urandom_range(0, 7) == 0) l1r = ~l1r;
      t.rst    = ($urandom_range(0, 199) != 0);
      t.req0   = ($urandom_range(0, 9) < 7);
      t.req1   = ($urandom_range(0, 9) < 7);
      t.lock0  = l0r;
      t.lock1  = l1r;
      t.rden0  = $urandom_range(0, 1);
      t.rden1  = $urandom_range(0, 1);
      t.wren0  = ($urandom_range(0, 3) == 0);
      t.wren1  = ($urandom_range(0, 3) == 0);
      t.addr0  = ADDR_W'($urandom_range(0, 15));
      t.addr1  = ADDR_W'($urandom_range(0, 15));
      t.be0    = $urandom;
      t.be1    = $urandom;
      t.wdata0 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      t.wdata1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      apply_stimulus(t);
    end
    for (int i = 0; i < RD_LAT + 2; i++) apply_stimulus(z);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
